// File: rtl/stream_muxn_pkg.sv
// Shared types and the round-robin search helper for stream_muxn.
package mux_pkg;

  typedef enum logic {
    MODE_SELECT = 1'b0,
    MODE_RR     = 1'b1
  } arb_mode_e;

  // Upper bound on channel count that rr_next can search.
  localparam int unsigned MAX_CH = 32;
  localparam int unsigned IDX_W  = 5;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_res_t;

  // First set bit of valid[0..n-1], searching upward from ptr+1 with wrap.
  function automatic rr_res_t rr_next(input logic [MAX_CH-1:0] valid,
                                      input logic [IDX_W-1:0]  ptr,
                                      input int unsigned       n);
    rr_res_t     res;
    int unsigned c;
    res = '0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      c = 32'(ptr) + i;
      if (c >= n) c = c - n;
      if (i <= n && !res.found && valid[c[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = c[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_muxn_skid_fifo2.sv
// Two-entry registered FIFO. Head entry is always presented on rdata_o;
// not_full_o is registered so downstream ready has no combinational pop path.
module skid_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [1:0]       count_o,
  output logic             not_full_o
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             r_not_full;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  // Guard push/pop against full/empty and derive the next occupancy.
  always_comb begin
    w_push      = push_i && (r_count != 2'd2);
    w_pop       = pop_i && (r_count != 2'd0);
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 2'd1;
  end

  // Storage: a pop shifts tail into head; push fills the first free slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_not_full <= 1'b0;
    end else begin
      if (w_pop) begin
        // Push alongside a pop is only possible at count 1: new word becomes head.
        if (w_push) r_head <= wdata_i;
        else        r_head <= r_tail;
      end else if (w_push) begin
        if (r_count == 2'd0) r_head <= wdata_i;
        else                 r_tail <= wdata_i;
      end
      r_count    <= w_count_nxt;
      r_not_full <= (w_count_nxt != 2'd2);
    end
  end

  assign rdata_o    = r_head;
  assign count_o    = r_count;
  assign not_full_o = r_not_full;

endmodule

// File: rtl/stream_muxn.sv
// N:1 valid/ready stream multiplexer, explicit-select or round-robin,
// feeding a 2-entry registered output buffer tagged with the source index.
module stream_muxn
  import mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 3,
  parameter int unsigned SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             mode_i,
  input  logic [SEL_W-1:0]                 sel_i,
  input  logic [NUM_INPUTS-1:0]            in_valid_i,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data_i,
  output logic [NUM_INPUTS-1:0]            in_ready_o,
  output logic                             out_valid_o,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic [SEL_W-1:0]                 out_src_o,
  input  logic                             out_ready_i,
  output logic                             err_o
);

  arb_mode_e                 w_mode;
  logic                      w_sel_ok;
  rr_res_t                   w_rr;
  logic                      w_rr_ok;
  logic                      w_grant_valid;
  logic [SEL_W-1:0]          w_grant;
  logic [NUM_INPUTS-1:0]     w_ready;
  logic                      w_can_accept;
  logic                      w_push;
  logic                      w_pop;
  logic [DATA_WIDTH-1:0]     w_payload;
  logic [1:0]                w_count;
  logic [DATA_WIDTH+SEL_W-1:0] w_rdata;
  logic [SEL_W-1:0]          r_rr_ptr;
  logic                      r_err;

  assign w_mode   = arb_mode_e'(mode_i);
  assign w_sel_ok = (32'(sel_i) < NUM_INPUTS);
  assign w_rr     = rr_next(MAX_CH'(in_valid_i), IDX_W'(r_rr_ptr), NUM_INPUTS);
  assign w_rr_ok  = w_rr.found && (32'(w_rr.idx) < NUM_INPUTS);

  // Grant selection; out-of-range select grants nothing.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    if (w_mode == MODE_SELECT) begin
      if (w_sel_ok) begin
        w_grant_valid = 1'b1;
        w_grant       = sel_i;
      end
    end else if (w_rr_ok) begin
      w_grant_valid = 1'b1;
      w_grant       = w_rr.idx[SEL_W-1:0];
    end
  end

  // One-hot ready on the granted channel while the buffer has room.
  always_comb begin
    w_ready = '0;
    if (w_can_accept && w_grant_valid) w_ready[w_grant] = 1'b1;
  end

  assign in_ready_o  = w_ready;
  assign w_push      = |(in_valid_i & w_ready);
  assign w_payload   = in_data_i[w_grant*DATA_WIDTH +: DATA_WIDTH];
  assign out_valid_o = (w_count != 2'd0);
  assign w_pop       = out_valid_o && out_ready_i;

  skid_fifo2 #(
    .WIDTH(DATA_WIDTH + SEL_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (w_push),
    .pop_i     (w_pop),
    .wdata_i   ({w_payload, w_grant}),
    .rdata_o   (w_rdata),
    .count_o   (w_count),
    .not_full_o(w_can_accept)
  );

  assign out_data_o = w_rdata[DATA_WIDTH+SEL_W-1:SEL_W];
  assign out_src_o  = w_rdata[SEL_W-1:0];

  // Sticky select-range error and round-robin pointer (moves only on RR pushes).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= SEL_W'(NUM_INPUTS - 1);
      r_err    <= 1'b0;
    end else begin
      if (w_mode == MODE_SELECT && !w_sel_ok) r_err <= 1'b1;
      if (w_push && w_mode == MODE_RR)        r_rr_ptr <= w_grant;
    end
  end

  assign err_o = r_err;

endmodule

// File: tb/tb_stream_muxn.sv
// Directed and randomised checks of stream_muxn against a queue-based model.
module tb_stream_muxn;

  localparam int N  = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          mode_i = 1'b0;
  logic [1:0]    sel_i = '0;
  logic [N-1:0]  in_valid_i = '0;
  logic [N*DW-1:0] in_data_i = '0;
  logic [N-1:0]  in_ready_o;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic [1:0]    out_src_o;
  logic          out_ready_i = 1'b0;
  logic          err_o;

  stream_muxn #(
    .DATA_WIDTH(DW),
    .NUM_INPUTS(N)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .mode_i     (mode_i),
    .sel_i      (sel_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_src_o  (out_src_o),
    .out_ready_i(out_ready_i),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model state: queue of accepted {src, data}, rr pointer, sticky error, accept flag.
  logic [33:0] mq[$];
  int          m_rr;
  bit          m_err;
  bit          m_can;

  // Observations of the DUT for literal sequence checks.
  int          dut_push_cnt;
  logic [1:0]  log_src[$];
  logic [31:0] log_data[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr  = N - 1;
    m_err = 1'b0;
    m_can = 1'b0;
  endtask

  function automatic void model_grant(output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (mode_i == 1'b0) begin
      if (int'(sel_i) < N) begin
        gv = 1'b1;
        g  = int'(sel_i);
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_rr + i) % N;
        if (!gv && in_valid_i[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
  endfunction

  // One clock: compare DUT to model, advance model across the rising edge.
  task automatic step();
    bit         gv;
    int         g;
    logic [2:0] exp_rdy;
    bit         push;
    bit         pop;
    #1;
    model_grant(gv, g);
    exp_rdy = (m_can && gv) ? 3'(1 << g) : 3'b000;
    chk("in_ready", 64'(in_ready_o), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
    chk("err", 64'(err_o), 64'(m_err));
    if (mq.size() != 0) begin
      chk("out_data", 64'(out_data_o), 64'(mq[0][31:0]));
      chk("out_src", 64'(out_src_o), 64'(mq[0][33:32]));
    end
    if (|(in_valid_i & in_ready_o)) dut_push_cnt++;
    if (out_valid_o && out_ready_i) begin
      log_src.push_back(out_src_o);
      log_data.push_back(out_data_o);
    end
    push = gv && in_valid_i[g] && m_can;
    pop  = (mq.size() != 0) && out_ready_i;
    @(posedge clk);
    if (mode_i == 1'b0 && int'(sel_i) >= N) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({2'(g), in_data_i[g*DW +: DW]});
    if (push && mode_i) m_rr = g;
    m_can = (mq.size() < 2);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid_i  = '0;
    out_ready_i = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    dut_push_cnt = 0;

    // Reset values while held in reset.
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_data", 64'(out_data_o), 64'd0);
    chk("rst_out_src", 64'(out_src_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Fill to two entries in RR mode, then reset asynchronously mid-cycle.
    mode_i      = 1'b1;
    in_valid_i  = 3'b111;
    out_ready_i = 1'b0;
    in_data_i   = {32'h2222_0000, 32'h1111_0000, 32'h0000_0000};
    for (int i = 0; i < 3; i++) step();
    chk("full_valid", 64'(out_valid_o), 64'd1);
    chk("full_in_ready", 64'(in_ready_o), 64'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid_o), 64'd0);
    chk("arst_err", 64'(err_o), 64'd0);
    chk("arst_in_ready", 64'(in_ready_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    in_valid_i = '0;
    step();
    in_valid_i = 3'b111;
    #1;
    chk("rr_first_ch0", 64'(in_ready_o), 64'b001);
    in_valid_i = '0;
    idle(1);

    // SELECT sel=1, one word per cycle.
    mode_i      = 1'b0;
    sel_i       = 2'd1;
    in_valid_i  = 3'b111;
    out_ready_i = 1'b1;
    in_data_i[63:32] = 32'hA5A5_0001;
    step();
    chk("sel_data", 64'(out_data_o), 64'hA5A5_0001);
    chk("sel_src", 64'(out_src_o), 64'd1);
    for (int i = 2; i <= 5; i++) begin
      in_data_i[63:32] = 32'hA5A5_0000 + 32'(i);
      step();
    end
    chk("sel_thru_data", 64'(out_data_o), 64'hA5A5_0005);
    chk("sel_thru_valid", 64'(out_valid_o), 64'd1);
    idle(3);

    // Backpressure on ch2: exactly two accepted, then drained in order.
    sel_i        = 2'd2;
    in_valid_i   = 3'b100;
    out_ready_i  = 1'b0;
    dut_push_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      in_data_i[95:64] = 32'hC0DE_0000 + 32'(i);
      step();
    end
    chk("bp_accepted", 64'(dut_push_cnt), 64'd2);
    chk("bp_in_ready", 64'(in_ready_o), 64'd0);
    log_src.delete();
    log_data.delete();
    idle(3);
    chk("bp_drain_cnt", 64'(log_data.size()), 64'd2);
    if (log_data.size() == 2) begin
      chk("bp_drain0", 64'(log_data[0]), 64'hC0DE_0000);
      chk("bp_drain1", 64'(log_data[1]), 64'hC0DE_0001);
      chk("bp_src0", 64'(log_src[0]), 64'd2);
    end

    // Round robin with all channels valid, then with 3'b101.
    mode_i = 1'b1;
    in_data_i = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    log_src.delete();
    log_data.delete();
    in_valid_i  = 3'b111;
    out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    idle(2);
    chk("rr111_cnt", 64'(log_src.size()), 64'd6);
    if (log_src.size() >= 5) begin
      chk("rr111_seq", 64'({log_src[0], log_src[1], log_src[2], log_src[3], log_src[4]}),
          64'({2'd0, 2'd1, 2'd2, 2'd0, 2'd1}));
    end
    log_src.delete();
    log_data.delete();
    in_valid_i = 3'b101;
    for (int i = 0; i < 4; i++) step();
    idle(2);
    chk("rr101_cnt", 64'(log_src.size()), 64'd4);
    if (log_src.size() >= 4) begin
      chk("rr101_seq", 64'({log_src[0], log_src[1], log_src[2], log_src[3]}),
          64'({2'd0, 2'd2, 2'd0, 2'd2}));
    end

    // Out-of-range select: no ready, sticky error.
    mode_i      = 1'b0;
    sel_i       = 2'd3;
    in_valid_i  = 3'b111;
    out_ready_i = 1'b1;
    #1;
    chk("oor_in_ready", 64'(in_ready_o), 64'd0);
    step();
    chk("oor_err_set", 64'(err_o), 64'd1);
    chk("oor_no_push", 64'(out_valid_o), 64'd0);
    sel_i = 2'd0;
    step();
    step();
    chk("oor_err_sticky", 64'(err_o), 64'd1);

    // Random soak against the model.
    for (int i = 0; i < 400; i++) begin
      mode_i      = 1'($urandom_range(0, 1));
      sel_i       = 2'($urandom_range(0, 3));
      in_valid_i  = 3'($urandom_range(0, 7));
      out_ready_i = ($urandom_range(0, 3) != 0);
      in_data_i   = {$urandom, $urandom, $urandom};
      step();
    end
    idle(4);
    chk("soak_drained", 64'(out_valid_o), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
